// File: rtl/psk_pkg.sv
//------------------------------------------------------------------------------
// psk_pkg
// Shared definitions for the PSK receive deframer:
//   - MODE_CTRL codes for BPSK, QPSK and the mixed BPSK-header/QPSK-payload mode
//   - the default frame sync word and its width
//   - the deframer FSM state encoding
//   - a helper that tells whether a MODE_CTRL value is one of the legal codes
//------------------------------------------------------------------------------
package psk_pkg;

    localparam logic [3:0] MODE_BPSK = 4'b0001;
    localparam logic [3:0] MODE_QPSK = 4'b0010;
    localparam logic [3:0] MODE_MIX  = 4'b0100;

    localparam int SYNC_BITS = 32;
    localparam int DIST_W    = 6;

    localparam logic [SYNC_BITS-1:0] DEFAULT_SYNC_WORD = 32'h1ACF_FC1D;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    // Only the three one-hot codes are usable; anything else keeps the
    // deframer hunting forever.
    function automatic logic isLegalMode(input logic [3:0] mode);
        return (mode == MODE_BPSK) || (mode == MODE_QPSK) || (mode == MODE_MIX);
    endfunction

endpackage

// File: rtl/sync_correlator.sv
//------------------------------------------------------------------------------
// sync_correlator
// Purely combinational Hamming-distance unit: counts the bit positions in
// which the receive window differs from the sync word.
// Ports:
//   i_window   - current 32-bit receive window (oldest bit in the MSB)
//   i_syncWord - reference sync word
//   o_dist     - number of differing bits, 0..32
//------------------------------------------------------------------------------
module sync_correlator
    import psk_pkg::*;
(
    input  logic [SYNC_BITS-1:0] i_window,
    input  logic [SYNC_BITS-1:0] i_syncWord,
    output logic [DIST_W-1:0]    o_dist
);

    logic [SYNC_BITS-1:0] w_diff;

    assign w_diff = i_window ^ i_syncWord;

    // Popcount of the difference vector; an adder chain is plenty at the
    // symbol rate this block runs at.
    always_comb begin
        o_dist = '0;
        for (int i = 0; i < SYNC_BITS; i++) begin
            o_dist = o_dist + {{(DIST_W-1){1'b0}}, w_diff[i]};
        end
    end

endmodule

// File: rtl/rx_deframer.sv
//------------------------------------------------------------------------------
// rx_deframer
// Finds the sync word in a demodulated bit stream (tolerating up to MAX_ERR
// bit errors and a 180-degree phase flip), reads the 8-bit length field and
// emits the payload as a byte stream with first/last markers.
// Ports:
//   clk_1M024   - symbol-rate clock
//   rst_n_1M024 - asynchronous active-low reset
//   MODE_CTRL   - 0001 BPSK, 0010 QPSK, 0100 MIX (BPSK header, QPSK payload)
//   bit_in      - demodulated symbol, bit_in[1] first; single-bit modes use [0]
//   bit_vld     - bit_in valid this cycle
//   data_tdata  - payload byte, MSB first
//   data_tvalid - one-cycle beat strobe (no back-pressure)
//   data_tuser  - first payload byte of a frame
//   data_tlast  - last payload byte of a frame
//   locked      - a frame is being received
//   inverted    - received bits are being complemented
//   len_err     - one-cycle pulse when a frame announces zero length
//------------------------------------------------------------------------------
module rx_deframer
    import psk_pkg::*;
#(
    parameter logic [SYNC_BITS-1:0] SYNC_WORD = DEFAULT_SYNC_WORD,
    parameter int unsigned          MAX_ERR   = 2
) (
    input  logic       clk_1M024,
    input  logic       rst_n_1M024,
    input  logic [3:0] MODE_CTRL,
    input  logic [1:0] bit_in,
    input  logic       bit_vld,
    output logic [7:0] data_tdata,
    output logic       data_tvalid,
    output logic       data_tuser,
    output logic       data_tlast,
    output logic       locked,
    output logic       inverted,
    output logic       len_err
);

    localparam logic [DIST_W-1:0] MAX_ERR_D = DIST_W'(MAX_ERR);
    localparam logic [DIST_W-1:0] FULL_D    = DIST_W'(SYNC_BITS);

    state_t               r_state;
    state_t               w_stateNext;
    logic [SYNC_BITS-1:0] r_window;
    logic [3:0]           r_mode;
    logic                 r_inverted;
    logic [2:0]           r_bitCnt;
    logic [7:0]           r_shift;
    logic [7:0]           r_len;
    logic [7:0]           r_byteCnt;
    logic [7:0]           r_tdata;
    logic                 r_tvalid;
    logic                 r_tuser;
    logic                 r_tlast;
    logic                 r_lenErr;

    logic [3:0]           w_mode;
    logic                 w_twoBits;
    logic                 w_b1;
    logic                 w_b0;
    logic [SYNC_BITS-1:0] w_windowNext;
    logic [DIST_W-1:0]    w_dist;
    logic                 w_trueHit;
    logic                 w_invHit;
    logic                 w_syncHit;
    logic [7:0]           w_byteNext;
    logic                 w_byteDone;
    logic                 w_lastByte;

    // While hunting the live MODE_CTRL decides how bits are taken; once
    // locked, the copy captured at sync detection rules the whole frame.
    assign w_mode    = (r_state == ST_HUNT) ? MODE_CTRL : r_mode;
    assign w_twoBits = (w_mode == MODE_QPSK) ||
                       ((w_mode == MODE_MIX) && (r_state == ST_PAYLOAD));

    // r_inverted is always clear in HUNT, so the window sees raw bits.
    assign w_b1 = bit_in[1] ^ r_inverted;
    assign w_b0 = bit_in[0] ^ r_inverted;

    assign w_windowNext = w_twoBits ? {r_window[SYNC_BITS-3:0], w_b1, w_b0}
                                    : {r_window[SYNC_BITS-2:0], w_b0};

    sync_correlator u_sync_correlator (
        .i_window   (w_windowNext),
        .i_syncWord (SYNC_WORD),
        .o_dist     (w_dist)
    );

    // A near-match of the complement means the carrier phase is off by
    // 180 degrees; MAX_ERR stays below 16 so both hits cannot coincide.
    assign w_trueHit = (w_dist <= MAX_ERR_D);
    assign w_invHit  = ((FULL_D - w_dist) <= MAX_ERR_D);
    assign w_syncHit = isLegalMode(MODE_CTRL) && (w_trueHit || w_invHit);

    assign w_byteNext = w_twoBits ? {r_shift[5:0], w_b1, w_b0}
                                  : {r_shift[6:0], w_b0};
    assign w_byteDone = w_twoBits ? (r_bitCnt == 3'd6) : (r_bitCnt == 3'd7);
    assign w_lastByte = (r_byteCnt == (r_len - 8'd1));

    // FSM state register.
    always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
        if (!rst_n_1M024) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: only valid bits move the FSM, and once out of HUNT
    // only byte boundaries of the header/payload can change state.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_HUNT: begin
                if (bit_vld && w_syncHit) begin
                    w_stateNext = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (bit_vld && w_byteDone) begin
                    w_stateNext = (w_byteNext == 8'd0) ? ST_HUNT : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (bit_vld && w_byteDone && w_lastByte) begin
                    w_stateNext = ST_HUNT;
                end
            end
            default: w_stateNext = ST_HUNT;
        endcase
    end

    // Datapath: sync window, bit/byte counters, byte assembly and the
    // registered output beat. Strobes default low every cycle; the byte
    // fields only change on a beat so they hold between beats. Leaving a
    // frame (normally or on a zero length) clears the window and the phase
    // correction so the next hunt starts clean.
    always_ff @(posedge clk_1M024 or negedge rst_n_1M024) begin
        if (!rst_n_1M024) begin
            r_window   <= '0;
            r_mode     <= '0;
            r_inverted <= 1'b0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_len      <= '0;
            r_byteCnt  <= '0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_tuser    <= 1'b0;
            r_tlast    <= 1'b0;
            r_lenErr   <= 1'b0;
        end else begin
            r_tvalid <= 1'b0;
            r_lenErr <= 1'b0;
            if (bit_vld) begin
                case (r_state)
                    ST_HUNT: begin
                        r_window <= w_windowNext;
                        if (w_syncHit) begin
                            r_mode     <= MODE_CTRL;
                            r_inverted <= ~w_trueHit;
                            r_bitCnt   <= '0;
                            r_shift    <= '0;
                        end
                    end
                    ST_HEADER: begin
                        r_shift  <= w_byteNext;
                        r_bitCnt <= r_bitCnt + (w_twoBits ? 3'd2 : 3'd1);
                        if (w_byteDone) begin
                            r_len     <= w_byteNext;
                            r_byteCnt <= '0;
                            if (w_byteNext == 8'd0) begin
                                r_lenErr   <= 1'b1;
                                r_inverted <= 1'b0;
                                r_window   <= '0;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        r_shift  <= w_byteNext;
                        r_bitCnt <= r_bitCnt + (w_twoBits ? 3'd2 : 3'd1);
                        if (w_byteDone) begin
                            r_tdata   <= w_byteNext;
                            r_tvalid  <= 1'b1;
                            r_tuser   <= (r_byteCnt == 8'd0);
                            r_tlast   <= w_lastByte;
                            r_byteCnt <= r_byteCnt + 8'd1;
                            if (w_lastByte) begin
                                r_inverted <= 1'b0;
                                r_window   <= '0;
                                r_byteCnt  <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_tdata  = r_tdata;
    assign data_tvalid = r_tvalid;
    assign data_tuser  = r_tuser;
    assign data_tlast  = r_tlast;
    assign locked      = (r_state != ST_HUNT);
    assign inverted    = r_inverted;
    assign len_err     = r_lenErr;

endmodule

// File: tb/tb_rx_deframer.sv
//------------------------------------------------------------------------------
// tb_rx_deframer
// Self-checking bench for rx_deframer. Frames are built as bit queues; the
// expected payload beats go into a scoreboard queue when a frame is queued
// and are popped and compared whenever the DUT raises data_tvalid.
//------------------------------------------------------------------------------
module tb_rx_deframer;
    import psk_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic       user;
        logic       last;
    } beat_t;

    localparam logic [31:0] SYNC = DEFAULT_SYNC_WORD;

    logic       clk_1M024 = 1'b0;
    logic       rst_n_1M024;
    logic [3:0] MODE_CTRL;
    logic [1:0] bit_in;
    logic       bit_vld;
    logic [7:0] data_tdata;
    logic       data_tvalid;
    logic       data_tuser;
    logic       data_tlast;
    logic       locked;
    logic       inverted;
    logic       len_err;

    beat_t expQ[$];
    logic  bitQ[$];

    int   nCompared     = 0;
    int   nMismatched   = 0;
    int   cycleCount    = 0;
    int   lastBeatCycle = -1;
    int   lenErrCount   = 0;
    logic lockedSeen    = 1'b0;

    rx_deframer #(
        .SYNC_WORD (SYNC),
        .MAX_ERR   (2)
    ) dut (
        .clk_1M024   (clk_1M024),
        .rst_n_1M024 (rst_n_1M024),
        .MODE_CTRL   (MODE_CTRL),
        .bit_in      (bit_in),
        .bit_vld     (bit_vld),
        .data_tdata  (data_tdata),
        .data_tvalid (data_tvalid),
        .data_tuser  (data_tuser),
        .data_tlast  (data_tlast),
        .locked      (locked),
        .inverted    (inverted),
        .len_err     (len_err)
    );

    always #5 clk_1M024 = ~clk_1M024;

    // One clock cycle: drive at the falling edge, let the DUT capture on the
    // rising edge, sample on the next falling edge and score any beat.
    task automatic applyStimulus(input logic vld, input logic [1:0] bits);
        beat_t exp;
        bit_vld = vld;
        bit_in  = vld ? bits : 2'($urandom_range(0, 3));
        @(posedge clk_1M024);
        @(negedge clk_1M024);
        cycleCount++;
        if (locked === 1'b1) lockedSeen = 1'b1;
        if (len_err === 1'b1) lenErrCount++;
        if (data_tvalid === 1'b1) begin
            lastBeatCycle = cycleCount;
            nCompared++;
            if (expQ.size() == 0) begin
                nMismatched++;
                $display("[TB] FAIL unexpected_beat got data=%h user=%b last=%b, required no beat",
                         data_tdata, data_tuser, data_tlast);
            end else begin
                exp = expQ.pop_front();
                if ({data_tdata, data_tuser, data_tlast} !== {exp.data, exp.user, exp.last}) begin
                    nMismatched++;
                    $display("[TB] FAIL beat got data=%h user=%b last=%b, required data=%h user=%b last=%b",
                             data_tdata, data_tuser, data_tlast, exp.data, exp.user, exp.last);
                end
            end
        end
    endtask

    task automatic pushField(input logic [31:0] value, input int nBits, input logic inv);
        for (int i = nBits - 1; i >= 0; i--) bitQ.push_back(value[i] ^ inv);
    endtask

    // Builds sync + LEN + nBytes payload bytes (taken MSB first from payload)
    // and, if wanted, records the beats the DUT should produce for them.
    task automatic queueFrame(input logic [31:0] syncw, input logic [7:0] len,
                              input logic [31:0] payload, input int nBytes,
                              input logic inv, input logic wantBeats);
        logic [31:0] p;
        beat_t b;
        p = payload;
        pushField(syncw, 32, inv);
        pushField({24'd0, len}, 8, inv);
        for (int i = 0; i < nBytes; i++) begin
            pushField({24'd0, p[31:24]}, 8, inv);
            if (wantBeats) begin
                b.data = p[31:24];
                b.user = (i == 0);
                b.last = (i == int'(len) - 1);
                expQ.push_back(b);
            end
            p = p << 8;
        end
    endtask

    task automatic sendBits(input int width, input int nSym, input int gap);
        logic [1:0] s;
        for (int i = 0; i < nSym; i++) begin
            s = 2'b00;
            if (width == 2) begin
                s[1] = bitQ.pop_front();
                s[0] = bitQ.pop_front();
            end else begin
                s[0] = bitQ.pop_front();
            end
            applyStimulus(1'b1, s);
            for (int g = 0; g < gap; g++) applyStimulus(1'b0, 2'b00);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00);
    endtask

    task automatic checkDrained(input string name);
        nCompared++;
        if (expQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL %s_beats_missing got %0d pending, required 0", name, expQ.size());
        end
        expQ.delete();
    endtask

    task automatic test_reset();
        rst_n_1M024 = 1'b0;
        MODE_CTRL   = MODE_BPSK;
        bit_vld     = 1'b0;
        bit_in      = 2'b00;
        idle(3);
        nCompared++;
        if ({data_tdata, data_tvalid, data_tuser, data_tlast, locked, inverted, len_err} !== 14'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs got %h, required 0",
                     {data_tdata, data_tvalid, data_tuser, data_tlast, locked, inverted, len_err});
        end
        rst_n_1M024 = 1'b1;
        idle(2);
    endtask

    task automatic test_bpsk_clean();
        MODE_CTRL = MODE_BPSK;
        queueFrame(SYNC, 8'd3, 32'hA53CFF00, 3, 1'b0, 1'b1);
        sendBits(1, 32, 0);
        nCompared++;
        if ({locked, inverted} !== 2'b10) begin
            nMismatched++;
            $display("[TB] FAIL clean_lock got locked/inverted=%b, required 10", {locked, inverted});
        end
        sendBits(1, 32, 0);
        idle(1);
        checkDrained("clean");
        nCompared++;
        if ({data_tvalid, data_tdata, data_tuser, data_tlast, locked} !== {1'b0, 8'hFF, 1'b0, 1'b1, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL clean_hold got valid/data/user/last/locked=%b/%h/%b/%b/%b, required 0/ff/0/1/0",
                     data_tvalid, data_tdata, data_tuser, data_tlast, locked);
        end
    endtask

    task automatic test_bpsk_inverted();
        MODE_CTRL = MODE_BPSK;
        queueFrame(SYNC, 8'd3, 32'hA53CFF00, 3, 1'b1, 1'b1);
        sendBits(1, 32, 0);
        nCompared++;
        if ({locked, inverted} !== 2'b11) begin
            nMismatched++;
            $display("[TB] FAIL inv_lock got locked/inverted=%b, required 11", {locked, inverted});
        end
        sendBits(1, 32, 0);
        idle(1);
        checkDrained("inverted");
        nCompared++;
        if ({locked, inverted} !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL inv_cleared got locked/inverted=%b, required 00", {locked, inverted});
        end
    endtask

    task automatic test_sync_errors();
        MODE_CTRL = MODE_BPSK;
        queueFrame(SYNC ^ 32'h8000_0001, 8'd1, 32'h5A000000, 1, 1'b0, 1'b1);
        sendBits(1, 32, 0);
        nCompared++;
        if (locked !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL err2_lock got locked=%b, required 1", locked);
        end
        sendBits(1, 16, 0);
        idle(1);
        checkDrained("err2");
        lockedSeen = 1'b0;
        queueFrame(SYNC ^ 32'h8000_8001, 8'd1, 32'h5A000000, 1, 1'b0, 1'b0);
        sendBits(1, 48, 0);
        idle(2);
        nCompared++;
        if (lockedSeen !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL err3_nolock got locked_seen=%b, required 0", lockedSeen);
        end
    endtask

    task automatic test_illegal_mode();
        lockedSeen = 1'b0;
        MODE_CTRL  = 4'b0011;
        queueFrame(SYNC, 8'd1, 32'h5A000000, 1, 1'b0, 1'b0);
        sendBits(1, 48, 0);
        MODE_CTRL = 4'b0000;
        queueFrame(SYNC, 8'd1, 32'h5A000000, 1, 1'b0, 1'b0);
        sendBits(2, 24, 0);
        idle(2);
        nCompared++;
        if (lockedSeen !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL illegal_mode_nolock got locked_seen=%b, required 0", lockedSeen);
        end
        MODE_CTRL = MODE_BPSK;
    endtask

    task automatic test_mix();
        int vldCycle;
        MODE_CTRL = MODE_MIX;
        queueFrame(SYNC, 8'd1, 32'h96000000, 1, 1'b0, 1'b1);
        sendBits(1, 32, 1);
        MODE_CTRL = MODE_BPSK;
        sendBits(1, 8, 1);
        sendBits(2, 3, 1);
        sendBits(2, 1, 0);
        vldCycle = cycleCount;
        nCompared++;
        if (lastBeatCycle != vldCycle) begin
            nMismatched++;
            $display("[TB] FAIL mix_latency got beat at cycle %0d, required %0d", lastBeatCycle, vldCycle);
        end
        idle(2);
        checkDrained("mix");
        nCompared++;
        if (locked !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL mix_unlock got locked=%b, required 0", locked);
        end
    endtask

    task automatic test_len_zero();
        int errBefore;
        MODE_CTRL = MODE_BPSK;
        errBefore = lenErrCount;
        queueFrame(SYNC, 8'd0, 32'h0, 0, 1'b0, 1'b0);
        sendBits(1, 40, 0);
        idle(3);
        nCompared++;
        if ((lenErrCount - errBefore) != 1) begin
            nMismatched++;
            $display("[TB] FAIL len0_pulse got %0d pulses, required 1", lenErrCount - errBefore);
        end
        nCompared++;
        if (locked !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL len0_unlock got locked=%b, required 0", locked);
        end
        queueFrame(SYNC, 8'd2, 32'h11220000, 2, 1'b0, 1'b1);
        sendBits(1, 56, 0);
        idle(1);
        checkDrained("len0_next");
    endtask

    task automatic test_back_to_back();
        MODE_CTRL = MODE_BPSK;
        queueFrame(SYNC, 8'd1, 32'h5A000000, 1, 1'b0, 1'b1);
        queueFrame(SYNC, 8'd1, 32'hC3000000, 1, 1'b1, 1'b1);
        sendBits(1, 96, 0);
        idle(1);
        checkDrained("back_to_back");
    endtask

    task automatic test_reset_midframe();
        MODE_CTRL = MODE_QPSK;
        queueFrame(SYNC, 8'd4, 32'h01020304, 1, 1'b0, 1'b1);
        sendBits(2, 24, 0);
        bitQ.push_back(1'b1);
        bitQ.push_back(1'b0);
        sendBits(2, 1, 0);
        checkDrained("midframe_byte1");
        #2;
        rst_n_1M024 = 1'b0;
        #1;
        nCompared++;
        if ({data_tdata, data_tvalid, data_tuser, data_tlast, locked, inverted, len_err} !== 14'd0) begin
            nMismatched++;
            $display("[TB] FAIL midframe_reset_outputs got %h, required 0",
                     {data_tdata, data_tvalid, data_tuser, data_tlast, locked, inverted, len_err});
        end
        idle(3);
        rst_n_1M024 = 1'b1;
        idle(2);
        queueFrame(SYNC, 8'd2, 32'hABCD0000, 2, 1'b0, 1'b1);
        sendBits(2, 28, 0);
        idle(1);
        checkDrained("midframe_next");
    endtask

    initial begin
        test_reset();
        test_bpsk_clean();
        test_bpsk_inverted();
        test_sync_errors();
        test_illegal_mode();
        test_mix();
        test_len_zero();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
